// File: rtl/sd_serdes_pkg.sv
// Shared constants for the sd_serdes serializer/deserializer.
// FSM state encodings, idle line level and beat widths.
package sd_serdes_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SYNC  = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic IDLE_LVL = 1'b1;

  localparam int W_NARROW = 1;
  localparam int W_WIDE   = 4;

endpackage

// File: rtl/sd_beat_counter.sv
// Down-counter of remaining beats in a frame; flags the final beat.
// Loaded with the beat count at frame acceptance, decremented once per shifted beat.
module sd_beat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (load_i) begin
        cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sd_serdes.sv
// Parallel<->serial frame engine over 1 or 4 lanes, MSB first.
// Define SD_SERDES_FRAMING_EN to add start/end beats and framing-error detection.
//
// state | meaning
// IDLE  | waiting for iStart, lines idle high
// SYNC  | TX: start beat on the line / RX: waiting for start beat (framing only)
// SHIFT | one data beat per enabled cycle
// STOP  | TX: end beat on the line / RX: end beat checked (framing only)
// DONE  | one-cycle completion pulse
module sd_serdes
  import sd_serdes_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int FS_W   = 8
) (
  input  logic              iSD_clock,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic              iMode,
  input  logic              iWide,
  input  logic              iStart,
  input  logic [FS_W-1:0]   iFrame_size,
  input  logic [DATA_W-1:0] iParallel,
  input  logic [LANES-1:0]  iSerial,
  output logic [LANES-1:0]  oSerial,
  output logic              oSerial_oe,
  output logic [DATA_W-1:0] oParallel,
  output logic              oBusy,
  output logic              oComplete,
  output logic              oError
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              wide_q, wide_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [2:0]        rem_q, rem_d;
  logic [LANES-1:0]  ser_q, ser_d;
  logic [DATA_W-1:0] par_q, par_d;

  logic              wide_in;
  logic [31:0]       s_eff;
  logic [CNT_W-1:0]  beats_in;
  logic [DATA_W-1:0] tx_align;
  logic [3:0]        ser_in4;
  logic [2:0]        rx_amt;
  logic [3:0]        rx_bits;
  logic [DATA_W-1:0] rx_next;
  logic              cnt_load, cnt_dec, cnt_last;

  function automatic logic [LANES-1:0] tx_beat(input logic [DATA_W-1:0] d, input logic w);
    logic [3:0]       top4;
    logic [LANES-1:0] b;
    top4 = d[DATA_W-1 -: 4];
    b    = {LANES{IDLE_LVL}};
    if (w) b = top4[LANES-1:0];
    else   b[0] = d[DATA_W-1];
    return b;
  endfunction

  sd_beat_counter #(.CNT_W(CNT_W)) u_beat_counter (
    .clk_i      (iSD_clock),
    .rst_b_i    (iReset),
    .en_i       (iEnable),
    .load_i     (cnt_load),
    .load_val_i (beats_in),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

  // Frame parameters derived from the request inputs at acceptance time.
  always_comb begin
    wide_in  = iWide & (LANES == 4);
    s_eff    = (32'(iFrame_size) > 32'(DATA_W)) ? 32'(DATA_W) : 32'(iFrame_size);
    beats_in = wide_in ? CNT_W'((s_eff + 32'd3) >> 2) : CNT_W'(s_eff);
    tx_align = iParallel << (32'(DATA_W) - s_eff);
    ser_in4  = '0;
    ser_in4[LANES-1:0] = iSerial;
  end

  // A short final wide beat keeps only its upper rem_q lanes.
  always_comb begin
    rx_amt  = wide_q ? (cnt_last ? rem_q : 3'd4) : 3'd1;
    rx_bits = wide_q ? (cnt_last ? (ser_in4 >> (3'd4 - rem_q)) : ser_in4)
                     : {3'b000, ser_in4[0]};
    rx_next = (dat_q << rx_amt) | DATA_W'(rx_bits);
  end

`ifdef SD_SERDES_FRAMING_EN
  logic       err_q, err_d;
  logic [3:0] mask4;
  logic [LANES-1:0] start_beat;

  always_comb begin
    mask4      = wide_q ? 4'hF : 4'h1;
    start_beat = {LANES{IDLE_LVL}};
    if (wide_in) start_beat = '0;
    else         start_beat[0] = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    wide_d   = wide_q;
    dat_d    = dat_q;
    rem_d    = rem_q;
    ser_d    = ser_q;
    par_d    = par_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef SD_SERDES_FRAMING_EN
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ser_d = {LANES{IDLE_LVL}};
        if (iStart && (s_eff != 32'd0)) begin
          mode_d   = iMode;
          wide_d   = wide_in;
          rem_d    = wide_in ? ((s_eff[1:0] == 2'd0) ? 3'd4 : {1'b0, s_eff[1:0]}) : 3'd1;
          cnt_load = 1'b1;
`ifdef SD_SERDES_FRAMING_EN
          err_d    = 1'b0;
          state_d  = ST_SYNC;
          if (iMode) begin
            dat_d = tx_align;
            ser_d = start_beat;
          end else begin
            dat_d = '0;
          end
`else
          state_d = ST_SHIFT;
          if (iMode) begin
            ser_d = tx_beat(tx_align, wide_in);
            dat_d = tx_align << (wide_in ? W_WIDE : W_NARROW);
          end else begin
            dat_d = '0;
          end
`endif
        end
      end
`ifdef SD_SERDES_FRAMING_EN
      ST_SYNC: begin
        if (mode_q) begin
          ser_d   = tx_beat(dat_q, wide_q);
          dat_d   = dat_q << (wide_q ? W_WIDE : W_NARROW);
          state_d = ST_SHIFT;
        end else if ((ser_in4 & mask4) == 4'h0) begin
          state_d = ST_SHIFT;
        end
      end
      ST_STOP: begin
        ser_d   = {LANES{IDLE_LVL}};
        state_d = ST_DONE;
        if (!mode_q) begin
          par_d = dat_q;
          err_d = ((ser_in4 & mask4) != mask4);
        end
      end
`endif
      ST_SHIFT: begin
        cnt_dec = 1'b1;
        if (mode_q) begin
          if (cnt_last) begin
            ser_d = {LANES{IDLE_LVL}};
          end else begin
            ser_d = tx_beat(dat_q, wide_q);
            dat_d = dat_q << (wide_q ? W_WIDE : W_NARROW);
          end
        end else begin
          dat_d = rx_next;
        end
        if (cnt_last) begin
`ifdef SD_SERDES_FRAMING_EN
          state_d = ST_STOP;
`else
          state_d = ST_DONE;
          if (!mode_q) par_d = rx_next;
`endif
        end
      end
      ST_DONE: begin
        ser_d   = {LANES{IDLE_LVL}};
        state_d = ST_IDLE;
      end
      default: begin
        ser_d   = {LANES{IDLE_LVL}};
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iSD_clock) begin
    if (!iReset) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      wide_q  <= 1'b0;
      dat_q   <= '0;
      rem_q   <= 3'd1;
      ser_q   <= {LANES{IDLE_LVL}};
      par_q   <= '0;
    end else if (iEnable) begin
      state_q <= state_d;
      mode_q  <= mode_d;
      wide_q  <= wide_d;
      dat_q   <= dat_d;
      rem_q   <= rem_d;
      ser_q   <= ser_d;
      par_q   <= par_d;
    end
  end

`ifdef SD_SERDES_FRAMING_EN
  always_ff @(posedge iSD_clock) begin
    if (!iReset)      err_q <= 1'b0;
    else if (iEnable) err_q <= err_d;
  end
  assign oError = err_q & (state_q == ST_DONE);
`else
  assign oError = 1'b0;
`endif

  assign oSerial    = ser_q;
  assign oSerial_oe = mode_q & ((state_q == ST_SYNC) | (state_q == ST_SHIFT) | (state_q == ST_STOP));
  assign oParallel  = par_q;
  assign oBusy      = (state_q != ST_IDLE);
  assign oComplete  = (state_q == ST_DONE);

endmodule

// File: tb/tb_sd_serdes.sv
// Directed self-checking bench for sd_serdes (DATA_W=32, LANES=4, FS_W=8).
// Framing-dependent steps follow SD_SERDES_FRAMING_EN.
module tb_sd_serdes;

  localparam int DW  = 32;
  localparam int LN  = 4;
  localparam int FSW = 8;

  logic          clk = 1'b0;
  logic          iReset, iEnable, iMode, iWide, iStart;
  logic [FSW-1:0] iFrame_size;
  logic [DW-1:0] iParallel;
  logic [LN-1:0] iSerial;
  logic [LN-1:0] oSerial;
  logic          oSerial_oe;
  logic [DW-1:0] oParallel;
  logic          oBusy, oComplete, oError;

  int total = 0;
  int bad   = 0;
  logic [3:0] vec [32];

  always #5 clk = ~clk;

  sd_serdes #(.DATA_W(DW), .LANES(LN), .FS_W(FSW)) dut (
    .iSD_clock   (clk),
    .iReset      (iReset),
    .iEnable     (iEnable),
    .iMode       (iMode),
    .iWide       (iWide),
    .iStart      (iStart),
    .iFrame_size (iFrame_size),
    .iParallel   (iParallel),
    .iSerial     (iSerial),
    .oSerial     (oSerial),
    .oSerial_oe  (oSerial_oe),
    .oParallel   (oParallel),
    .oBusy       (oBusy),
    .oComplete   (oComplete),
    .oError      (oError)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nibs(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) vec[i] = v[4*(n-1-i) +: 4];
  endtask

  task automatic start(input logic m, input logic w, input int size, input logic [31:0] par);
    iMode = m; iWide = w; iFrame_size = FSW'(size); iParallel = par; iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic run_tx(input string tag, input logic w, input int size, input logic [31:0] par, input int n);
    start(1'b1, w, size, par);
`ifdef SD_SERDES_FRAMING_EN
    chk({tag, "_startbeat"}, 32'(oSerial), w ? 32'h0 : 32'hE);
    tick();
`endif
    for (int i = 0; i < n; i++) begin
      chk({tag, "_beat"}, 32'(oSerial), 32'(vec[i]));
      chk({tag, "_oe"}, 32'(oSerial_oe), 32'd1);
      tick();
    end
`ifdef SD_SERDES_FRAMING_EN
    chk({tag, "_endbeat"}, 32'(oSerial), 32'hF);
    tick();
`endif
    chk({tag, "_complete"}, 32'(oComplete), 32'd1);
    chk({tag, "_idle_line"}, 32'(oSerial), 32'hF);
    chk({tag, "_oe_off"}, 32'(oSerial_oe), 32'd0);
    tick();
    chk({tag, "_busy_off"}, 32'(oBusy), 32'd0);
  endtask

  task automatic run_rx(input string tag, input logic w, input int size, input int n, input logic [31:0] exp_par);
    start(1'b0, w, size, 32'h0);
`ifdef SD_SERDES_FRAMING_EN
    iSerial = w ? 4'h0 : 4'hE;
    tick();
`endif
    for (int i = 0; i < n; i++) begin
      chk({tag, "_no_early_complete"}, 32'(oComplete), 32'd0);
      iSerial = vec[i];
      tick();
    end
`ifdef SD_SERDES_FRAMING_EN
    iSerial = 4'hF;
    tick();
`endif
    iSerial = 4'hF;
    chk({tag, "_complete"}, 32'(oComplete), 32'd1);
    chk({tag, "_parallel"}, oParallel, exp_par);
    chk({tag, "_error"}, 32'(oError), 32'd0);
  endtask

  initial begin
    logic        seen;
    logic [15:0] bits16;
    iReset = 1'b0; iEnable = 1'b0; iMode = 1'b0; iWide = 1'b0; iStart = 1'b0;
    iFrame_size = '0; iParallel = '0; iSerial = 4'hF;

    // reset, with enable low
    tick(); tick();
    chk("rst_serial", 32'(oSerial), 32'hF);
    chk("rst_oe", 32'(oSerial_oe), 32'd0);
    chk("rst_parallel", oParallel, 32'h0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_complete", 32'(oComplete), 32'd0);
    chk("rst_error", 32'(oError), 32'd0);
    iReset = 1'b1; iEnable = 1'b1;
    tick();

    // TX 1 lane, 0xA5 -> 1,0,1,0,0,1,0,1 on lane 0, lanes 3..1 idle high
    set_nibs(32'hFEFE_EFEF, 8);
    run_tx("tx_a5", 1'b0, 8, 32'h0000_00A5, 8);

    // RX 4 lanes, 32 bits
    set_nibs(32'hDEAD_BEEF, 8);
    run_rx("rx_deadbeef", 1'b1, 32, 8, 32'hDEAD_BEEF);
    tick();

    // RX 4 lanes, 6 bits: second beat keeps its upper two lanes
    set_nibs(32'h0000_00BC, 2);
    run_rx("rx_s6", 1'b1, 6, 2, 32'h0000_002F);
    iEnable = 1'b0;
    tick(); tick();
    chk("freeze_done_complete", 32'(oComplete), 32'd1);
    chk("freeze_done_parallel", oParallel, 32'h0000_002F);
    iEnable = 1'b1;
    tick();
    chk("after_done_complete", 32'(oComplete), 32'd0);
    chk("after_done_busy", 32'(oBusy), 32'd0);

    // TX 4 lanes, 6 bits of 0x..EF (101111): beats 1011, 11 padded to 1100
    set_nibs(32'h0000_00BC, 2);
    run_tx("tx_s6", 1'b1, 6, 32'h1234_56EF, 2);

    // frame size above DATA_W clamps to 32 bits
    set_nibs(32'h1234_5678, 8);
    run_tx("tx_clamp", 1'b1, 255, 32'h1234_5678, 8);

    // RX 1 lane, 5 bits 10110; lanes 3..1 carry noise that must be ignored
    set_nibs(32'h000B_ABBA, 5);
    run_rx("rx_narrow", 1'b0, 5, 5, 32'h0000_0016);
    tick();

    // zero-size start is ignored
    iMode = 1'b1; iWide = 1'b0; iFrame_size = '0; iParallel = 32'hFFFF_FFFF; iStart = 1'b1;
    tick();
    chk("zero_busy", 32'(oBusy), 32'd0);
    chk("zero_complete", 32'(oComplete), 32'd0);
    chk("zero_serial", 32'(oSerial), 32'hF);
    // accepted frame, then iStart held with different request while busy
    iFrame_size = FSW'(4); iParallel = 32'h0000_000A;
    tick();
`ifdef SD_SERDES_FRAMING_EN
    tick();
`endif
    iMode = 1'b0; iWide = 1'b1; iFrame_size = FSW'(8); iParallel = 32'h0;
    set_nibs(32'h0000_FEFE, 4);
    for (int i = 0; i < 4; i++) begin
      chk("busy_start_beat", 32'(oSerial), 32'(vec[i]));
      chk("busy_start_oe", 32'(oSerial_oe), 32'd1);
      if (i == 3) iStart = 1'b0;
      tick();
    end
`ifdef SD_SERDES_FRAMING_EN
    tick();
`endif
    iStart = 1'b0;
    chk("busy_start_complete", 32'(oComplete), 32'd1);
    tick();
    chk("busy_start_idle", 32'(oBusy), 32'd0);

    // TX 16 bits, freeze 3 cycles, then reset while beat 10 is on the line
    bits16 = 16'hC3A5;
    start(1'b1, 1'b0, 16, 32'h0000_C3A5);
`ifdef SD_SERDES_FRAMING_EN
    tick();
`endif
    for (int k = 0; k < 5; k++) begin
      chk("frz_beat", 32'(oSerial), {28'h0, 3'b111, bits16[15-k]});
      tick();
    end
    iEnable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_hold_line", 32'(oSerial), {28'h0, 3'b111, bits16[10]});
      chk("frz_hold_busy", 32'(oBusy), 32'd1);
      chk("frz_hold_oe", 32'(oSerial_oe), 32'd1);
    end
    iEnable = 1'b1;
    for (int k = 5; k < 11; k++) begin
      chk("frz_resume_beat", 32'(oSerial), {28'h0, 3'b111, bits16[15-k]});
      if (k < 10) tick();
    end
    iReset = 1'b0;
    tick();
    chk("abort_serial", 32'(oSerial), 32'hF);
    chk("abort_oe", 32'(oSerial_oe), 32'd0);
    chk("abort_busy", 32'(oBusy), 32'd0);
    chk("abort_parallel", oParallel, 32'h0);
    iReset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (oComplete || oBusy) seen = 1'b1;
    end
    chk("abort_no_complete", 32'(seen), 32'd0);

`ifdef SD_SERDES_FRAMING_EN
    // RX 1 lane, 4 bits with a bad end bit
    start(1'b0, 1'b0, 4, 32'h0);
    iSerial = 4'hF;
    tick(); tick();
    chk("frm_wait_sync", 32'(oBusy), 32'd1);
    chk("frm_wait_nocomplete", 32'(oComplete), 32'd0);
    iSerial = 4'hE; tick();
    iSerial = 4'hF; tick();
    iSerial = 4'hE; tick();
    iSerial = 4'hE; tick();
    iSerial = 4'hF; tick();
    iSerial = 4'hE; tick();
    iSerial = 4'hF;
    chk("frm_complete", 32'(oComplete), 32'd1);
    chk("frm_error", 32'(oError), 32'd1);
    chk("frm_parallel", oParallel, 32'h0000_0009);
    tick();
    chk("frm_error_pulse", 32'(oError), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_serdes.md
SD_SERDES -- requirements
Module: sd_serdes

Interface
REQ-001 SHALL have parameter DATA_W, default 32: parallel word width, legal 8..32.
REQ-002 SHALL have parameter LANES, default 4: physical serial lanes, legal 1 or 4.
REQ-003 SHALL have parameter FS_W, default 8: width of iFrame_size.
REQ-004 SHALL have port iSD_clock  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port iReset  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port iEnable  in  1  clock enable; low freezes all state.
REQ-007 SHALL have port iMode  in  1  1 = transmit (parallel->serial), 0 = receive (serial->parallel).
REQ-008 SHALL have port iWide  in  1  1 = use all LANES lanes, 0 = lane 0 only; ignored when LANES=1.
REQ-009 SHALL have port iStart  in  1  frame start request.
REQ-010 SHALL have port iFrame_size  in  FS_W  data bits per frame.
REQ-011 SHALL have port iParallel  in  DATA_W  transmit word.
REQ-012 SHALL have port iSerial  in  LANES  receive lines.
REQ-013 SHALL have port oSerial  out  LANES  transmit lines.
REQ-014 SHALL have port oSerial_oe  out  1  drive enable for oSerial.
REQ-015 SHALL have port oParallel  out  DATA_W  received word.
REQ-016 SHALL have port oBusy  out  1  frame in progress.
REQ-017 SHALL have port oComplete  out  1  one-cycle frame-done pulse.
REQ-018 SHALL have port oError  out  1  one-cycle framing-error pulse.

Function
REQ-019 FSM states SHALL be IDLE, SYNC, SHIFT, STOP, DONE; SYNC and STOP exist only with SD_SERDES_FRAMING_EN.
REQ-020 iStart SHALL be accepted only in IDLE with iEnable high; iMode, iWide, iFrame_size, iParallel latched that cycle; iStart outside IDLE ignored.
REQ-021 Effective size S = min(iFrame_size, DATA_W); S=0 SHALL leave FSM in IDLE with no pulse.
REQ-022 Beat width W = 4 when LANES=4 and iWide=1, else 1; beats B = ceil(S/W).
REQ-023 Data SHALL be MSB-first; in 4-lane mode lane 3 carries the highest bit of each beat; a short last beat pads low lanes with 0 (TX) / discards them (RX).
REQ-024 TX: first data beat SHALL appear on oSerial the cycle after acceptance, one beat per enabled cycle; oSerial_oe high only during SYNC/SHIFT/STOP of a TX frame.
REQ-025 oSerial SHALL idle at all-ones; unused lanes in 1-lane mode SHALL stay 1.
REQ-026 RX: sample iSerial each enabled SHIFT cycle; after the last beat oParallel SHALL hold the S bits right-aligned, upper bits 0, until the next RX completion.
REQ-027 DONE SHALL last one cycle, assert oComplete, then return to IDLE; oBusy high in every state except IDLE.
REQ-028 iEnable low SHALL freeze state, counter, shift register and outputs, including an oComplete in progress.

Reset
REQ-029 iReset low at a clock edge SHALL force IDLE, oSerial all-ones, oSerial_oe 0, oParallel 0, oBusy 0, oComplete 0, oError 0, regardless of iEnable.
REQ-030 Reset mid-frame SHALL abort without oComplete and without updating oParallel.

Configuration
REQ-031 With SD_SERDES_FRAMING_EN defined: TX emits one start beat (active lanes 0) before data and one end beat (active lanes 1) after; RX waits in SYNC until all active lanes read 0, then shifts; in STOP any active lane not 1 pulses oError with oComplete; oParallel is still updated.
REQ-032 Without SD_SERDES_FRAMING_EN: raw data beats only, SHIFT follows IDLE directly, oError tied 0.

Structure
REQ-033 Package sd_serdes_pkg SHALL hold the state enum, idle-line level, and W constants (W_NARROW=1, W_WIDE=4).
REQ-034 Beat counting SHALL be a sub-module sd_beat_counter (load B, decrement on enable, flag last beat).

Verification
REQ-035 TX, 1 lane, S=8, iParallel=0xA5, no framing -> oSerial[0] 1,0,1,0,0,1,0,1 over 8 cycles, oComplete on cycle 9.
REQ-036 RX, 4 lanes, S=32, nibbles 0xD,0xE,0xA,0xD,0xB,0xE,0xE,0xF -> oParallel=0xDEADBEEF, oComplete after 8 beats.
REQ-037 RX, 4 lanes, S=6, nibbles 0xB,0xC -> oParallel=0x0000002F (upper 2 bits of beat 2 kept).
REQ-038 Framing on, RX, 1 lane, S=4: idle 1s, start 0, data 1001, end bit 0 -> oParallel=0x9, oComplete and oError same cycle.
REQ-039 TX 1 lane S=16, iEnable low 3 cycles mid-frame, then iReset low at beat 10 -> line holds during freeze, then all-ones, no oComplete, oBusy 0.
REQ-040 iStart with iFrame_size=0 and iStart while oBusy -> no state change, no pulse, frame in progress unaffected.
